// File: rtl/sprite_blitter_if.sv
// ============================================================================
//  Module      : sprite_blitter_if
//  Description : Sprite ROM row port plus frame-buffer write port
//                (ready/valid) used by sprite_blitter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sprite_blitter_if;
    logic [4:0]        row_sel;
    logic [31:0][23:0] row_data;
    logic              fb_we;
    logic              fb_ready;
    logic [9:0]        fb_x;
    logic [8:0]        fb_y;
    logic [23:0]       fb_rgb;

    // Blitter side: addresses the ROM and issues frame-buffer writes
    modport master (
        output row_sel, fb_we, fb_x, fb_y, fb_rgb,
        input  row_data, fb_ready
    );

    // ROM / frame-buffer side
    modport slave (
        input  row_sel, fb_we, fb_x, fb_y, fb_rgb,
        output row_data, fb_ready
    );
endinterface

`default_nettype wire

// File: rtl/sprite_blitter.sv
// ============================================================================
//  Module      : sprite_blitter
//  Description : Copies a 32x32 24-bit sprite, one ROM row at a time, into
//                the frame buffer at a latched screen position, skipping
//                transparent pixels. Optional screen-edge clipping is enabled
//                by defining SPRITE_BLITTER_CLIP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_blitter #(
    parameter int          SCREEN_W    = 640,
    parameter int          SCREEN_H    = 480,
    parameter logic [23:0] TRANSPARENT = 24'd0
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       start,
    input  wire logic [9:0] pos_x,
    input  wire logic [8:0] pos_y,
    output logic            busy,
    output logic            done,
    sprite_blitter_if.master bus
);

    localparam logic [10:0] c_screen_w = 11'(SCREEN_W);
    localparam logic [9:0]  c_screen_h = 10'(SCREEN_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [9:0]        r_pos_x;
    logic [8:0]        r_pos_y;
    logic [4:0]        r_row;
    logic [4:0]        r_col;
    logic [31:0][23:0] r_buf;
    logic              r_busy;
    logic              r_done;
    logic              r_fb_we;
    logic [9:0]        r_fb_x;
    logic [8:0]        r_fb_y;
    logic [23:0]       r_fb_rgb;

    // The fb outputs are registered, so the pixel for the column about to be
    // shown is evaluated one edge early: column 0 comes straight from the ROM
    // while leaving FETCH, later columns from the row buffer.
    logic        w_is_fetch;
    logic [4:0]  w_nxt_col;
    logic [4:0]  w_nxt_idx;
    logic [23:0] w_nxt_pix;
    logic [10:0] w_sum_x;
    logic [9:0]  w_sum_y;
    logic        w_clip;
    logic        w_nxt_wr;
    logic        w_advance;

    assign w_is_fetch = (r_state == S_FETCH);
    assign w_nxt_col  = w_is_fetch ? 5'd0 : (r_col + 5'd1);
    assign w_nxt_idx  = 5'd31 - w_nxt_col;
    assign w_nxt_pix  = w_is_fetch ? bus.row_data[w_nxt_idx] : r_buf[w_nxt_idx];
    assign w_sum_x    = {1'b0, r_pos_x} + {6'd0, w_nxt_col};
    assign w_sum_y    = {1'b0, r_pos_y} + {5'd0, r_row};

`ifdef SPRITE_BLITTER_CLIP_EN
    assign w_clip = (w_sum_x >= c_screen_w) || (w_sum_y >= c_screen_h);
`else
    // Caller keeps the sprite on-screen; the carry bits are simply dropped.
    logic w_unused_clip;
    assign w_clip        = 1'b0;
    assign w_unused_clip = ^{w_sum_x[10], w_sum_y[9], c_screen_w, c_screen_h};
`endif

    assign w_nxt_wr  = (w_nxt_pix != TRANSPARENT) && !w_clip;
    // A column completes when no write is pending or the pending one is taken
    assign w_advance = !r_fb_we || bus.fb_ready;

    // Blit sequencer: row fetch, per-column draw with handshake stall, done
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_pos_x  <= '0;
            r_pos_y  <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_buf    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_fb_we  <= 1'b0;
            r_fb_x   <= '0;
            r_fb_y   <= '0;
            r_fb_rgb <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_pos_x <= pos_x;
                        r_pos_y <= pos_y;
                        r_row   <= 5'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_buf   <= bus.row_data;
                    r_col   <= 5'd0;
                    r_fb_we <= w_nxt_wr;
                    if (w_nxt_wr) begin
                        r_fb_x   <= w_sum_x[9:0];
                        r_fb_y   <= w_sum_y[8:0];
                        r_fb_rgb <= w_nxt_pix;
                    end
                    r_state <= S_DRAW;
                end
                S_DRAW: begin
                    if (w_advance) begin
                        if (r_col == 5'd31) begin
                            r_fb_we <= 1'b0;
                            if (r_row == 5'd31) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_row   <= r_row + 5'd1;
                                r_state <= S_FETCH;
                            end
                        end else begin
                            r_col   <= w_nxt_col;
                            r_fb_we <= w_nxt_wr;
                            if (w_nxt_wr) begin
                                r_fb_x   <= w_sum_x[9:0];
                                r_fb_y   <= w_sum_y[8:0];
                                r_fb_rgb <= w_nxt_pix;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.row_sel = r_row;
    assign bus.fb_we   = r_fb_we;
    assign bus.fb_x    = r_fb_x;
    assign bus.fb_y    = r_fb_y;
    assign bus.fb_rgb  = r_fb_rgb;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sprite_blitter.sv
// ============================================================================
//  Module      : tb_sprite_blitter
//  Description : Directed, table-driven bench for sprite_blitter with a
//                combinational sprite ROM and a stalling frame-buffer sink.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_blitter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [9:0] pos_x = '0;
    logic [8:0] pos_y = '0;
    logic       busy;
    logic       done;

    sprite_blitter_if bus ();

    sprite_blitter dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .pos_x (pos_x),
        .pos_y (pos_y),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Sprite ROM model, zero latency
    logic [23:0] spr [0:31][0:31];
    always_comb begin
        for (int c = 0; c < 32; c++) bus.row_data[31-c] = spr[bus.row_sel][c];
    end

    int n_edge = 0;
    always @(posedge clk) n_edge <= n_edge + 1;

    int n_chk = 0;
    int n_err = 0;

    // Monitor / sink state
    logic [9:0]  tb_px;
    logic [8:0]  tb_py;
    int          stall_left = 0;
    int          n_wr, n_done, n_busy, done_cyc, bad_wr, stall_bad, oob;
    int          last_x, last_y, last_rgb, last_idx, first_idx;
    logic        prev_stall = 1'b0;
    logic [9:0]  sx;
    logic [8:0]  sy;
    logic [23:0] srgb;
    logic [9:0]  dc;
    logic [8:0]  dr;
    int          idx;

    task automatic clear_mon();
        n_wr = 0; n_done = 0; n_busy = 0; done_cyc = -1; bad_wr = 0;
        stall_bad = 0; oob = 0; last_x = -1; last_y = -1; last_rgb = -1;
        last_idx = -1; first_idx = -1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Sink: drives fb_ready, checks hold-during-stall and every accepted write
    always @(negedge clk) begin
        if (prev_stall) begin
            if (!(bus.fb_we && bus.fb_x == sx && bus.fb_y == sy && bus.fb_rgb == srgb))
                stall_bad++;
        end
        if (bus.fb_we && stall_left > 0) begin
            bus.fb_ready = 1'b0;
            stall_left--;
        end else begin
            bus.fb_ready = 1'b1;
        end
        prev_stall = bus.fb_we && !bus.fb_ready && !reset;
        sx = bus.fb_x; sy = bus.fb_y; srgb = bus.fb_rgb;
        if (bus.fb_we && bus.fb_ready && !reset) begin
            dc  = bus.fb_x - tb_px;
            dr  = bus.fb_y - tb_py;
            idx = int'(dr) * 32 + int'(dc);
            if (!(dc < 10'd32 && dr < 9'd32 && bus.fb_rgb != 24'd0 &&
                  spr[dr[4:0]][dc[4:0]] == bus.fb_rgb && idx > last_idx))
                bad_wr++;
            if (bus.fb_x >= 10'd640 || bus.fb_y >= 9'd480) oob++;
            if (n_wr == 0) first_idx = idx;
            last_idx = idx;
            last_x = int'(bus.fb_x); last_y = int'(bus.fb_y); last_rgb = int'(bus.fb_rgb);
            n_wr++;
        end
        if (done) begin
            if (n_done == 0) done_cyc = n_edge + 1;
            n_done++;
        end
        if (busy) n_busy++;
    end

    task automatic load_sprite(input int kind);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                spr[r][c] = (kind == 2) ? 24'd10526880 : 24'd0;
        if (kind == 1) spr[3][17] = 24'd16711680;
    endtask

    // Start on one edge; positions are scrambled afterwards to prove latching
    task automatic do_start(input logic [9:0] px, input logic [8:0] py, output int k);
        @(negedge clk);
        tb_px = px; tb_py = py;
        start = 1'b1; pos_x = px; pos_y = py;
        @(posedge clk);
        #1;
        k = n_edge;
        start = 1'b0;
        pos_x = px ^ 10'h155;
        pos_y = py ^ 9'h0AA;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000; i++) begin
            if (n_done != 0) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        int kind;
        int px;
        int py;
        int stall;
        int exp_wr;
        int exp_done;
        int exp_busy;
        int exp_x;
        int exp_y;
        int exp_rgb;
    } vec_t;

    vec_t vecs [6];
    int   k;
    logic hit;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 0,   0,   0, 0,    1057, 1056, 0,   0,   0};
        vecs[1] = '{1, 100, 50,  0, 1,    1057, 1056, 117, 53,  16711680};
        vecs[2] = '{1, 100, 50,  5, 1,    1062, 1061, 117, 53,  16711680};
`ifdef SPRITE_BLITTER_CLIP_EN
        vecs[3] = '{2, 630, 470, 0, 100,  1057, 1056, 639, 479, 10526880};
`else
        vecs[3] = '{2, 630, 470, 0, 1024, 1057, 1056, 661, 501, 10526880};
`endif
        vecs[4] = '{2, 0,   0,   0, 1024, 1057, 1056, 31,  31,  10526880};
        vecs[5] = '{1, 1,   2,   2, 1,    1059, 1058, 18,  5,   16711680};

        tb_px = '0; tb_py = '0;
        load_sprite(0);
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",    int'(busy), 0);
        chk("reset_done",    int'(done), 0);
        chk("reset_fb_we",   int'(bus.fb_we), 0);
        chk("reset_fb_x",    int'(bus.fb_x), 0);
        chk("reset_fb_y",    int'(bus.fb_y), 0);
        chk("reset_fb_rgb",  int'(bus.fb_rgb), 0);
        chk("reset_row_sel", int'(bus.row_sel), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            load_sprite(vecs[v].kind);
            @(posedge clk);
            #1;
            clear_mon();
            stall_left = vecs[v].stall;
            do_start(vecs[v].px[9:0], vecs[v].py[8:0], k);
            wait_done();
            $display("vector %0d: writes=%0d done_cycle=k+%0d", v, n_wr, done_cyc - k);
            chk($sformatf("v%0d_writes", v),   n_wr, vecs[v].exp_wr);
            chk($sformatf("v%0d_done_at", v),  done_cyc - k, vecs[v].exp_done);
            chk($sformatf("v%0d_done_cnt", v), n_done, 1);
            chk($sformatf("v%0d_busy_cyc", v), n_busy, vecs[v].exp_busy);
            chk($sformatf("v%0d_content", v),  bad_wr, 0);
            chk($sformatf("v%0d_stall_hold", v), stall_bad, 0);
`ifdef SPRITE_BLITTER_CLIP_EN
            chk($sformatf("v%0d_onscreen", v), oob, 0);
`endif
            if (vecs[v].exp_wr > 0) begin
                chk($sformatf("v%0d_last_x", v),   last_x, vecs[v].exp_x);
                chk($sformatf("v%0d_last_y", v),   last_y, vecs[v].exp_y);
                chk($sformatf("v%0d_last_rgb", v), last_rgb, vecs[v].exp_rgb);
            end
        end

        // Reset in the middle of row 10 while a write is pending
        load_sprite(2);
        @(posedge clk);
        #1;
        clear_mon();
        do_start(10'd0, 9'd0, k);
        hit = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (bus.row_sel == 5'd10 && bus.fb_we) begin
                hit = 1'b1;
                break;
            end
        end
        chk("rst_reached_row10", int'(hit), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_fb_we",   int'(bus.fb_we), 0);
        chk("rst_busy",    int'(busy), 0);
        chk("rst_done",    int'(done), 0);
        chk("rst_row_sel", int'(bus.row_sel), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        clear_mon();
        do_start(10'd5, 9'd5, k);
        chk("rst_restart_row_sel", int'(bus.row_sel), 0);
        wait_done();
        chk("rst_restart_first", first_idx, 0);
        chk("rst_restart_writes", n_wr, 1024);
        chk("rst_restart_content", bad_wr, 0);

        // start while busy and in the DONE cycle must both be ignored
        load_sprite(1);
        @(posedge clk);
        #1;
        clear_mon();
        do_start(10'd100, 9'd50, k);
        repeat (20) @(posedge clk);
        @(negedge clk);
        start = 1'b1; pos_x = 10'd200; pos_y = 9'd200;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                hit = 1'b1;
                break;
            end
        end
        chk("ign_done_seen", int'(hit), 1);
        start = 1'b1; pos_x = 10'd300; pos_y = 9'd300;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ign_busy_after_done", int'(busy), 0);
        repeat (1100) @(posedge clk);
        #1;
        chk("ign_done_cnt", n_done, 1);
        chk("ign_writes",   n_wr, 1);
        chk("ign_x",        last_x, 117);
        chk("ign_y",        last_y, 53);
        chk("ign_busy_idle", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
